// File: rtl/spu_ln_pkg.sv
// Shared constants for the SPU LayerNorm control path and datapath.
// Phase encodings here are the ones spu_ln_block decodes on ln_state.
package spu_ln_pkg;

    localparam logic [2:0] LN_IDLE      = 3'b000;
    localparam logic [2:0] LN_SUM_COUNT = 3'b001;
    localparam logic [2:0] LN_SUM_DIV   = 3'b011;
    localparam logic [2:0] LN_SQRT      = 3'b100;
    localparam logic [2:0] LN_OUT       = 3'b110;

    localparam int LN_MAX_WORDS = 512;
    localparam int LN_WADDR_W   = 9;
    localparam int LN_WR_LAT    = 3;

    // DONE is private to the sequencer and is shown as IDLE to the datapath
    typedef enum logic [2:0] {
        ST_IDLE      = LN_IDLE,
        ST_SUM_COUNT = LN_SUM_COUNT,
        ST_SUM_DIV   = LN_SUM_DIV,
        ST_SQRT      = LN_SQRT,
        ST_OUT       = LN_OUT,
        ST_DONE      = 3'b111
    } ln_ctrl_st_e;

    function automatic logic [9:0] ln_clamp_len(input logic [9:0] len, input int max_w);
        if (int'(len) > max_w) return 10'(max_w);
        return len;
    endfunction

endpackage

// File: rtl/spu_ln_wr_delay.sv
// Fixed-depth {valid, addr} delay line that turns OUT-phase reads into
// output-buffer writes aligned with the datapath output register.
module spu_ln_wr_delay #(
    parameter int AW    = 9,
    parameter int DEPTH = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          vld_i,
    input  logic [AW-1:0] addr_i,
    output logic          vld_o,
    output logic [AW-1:0] addr_o,
    output logic          busy_o
);

    logic [DEPTH-1:0]         vld_pipe_q;
    logic [DEPTH-1:0][AW-1:0] addr_pipe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[DEPTH-2:0], vld_i};
            addr_pipe_q <= {addr_pipe_q[DEPTH-2:0], addr_i};
        end
    end

    assign vld_o  = vld_pipe_q[DEPTH-1];
    assign addr_o = addr_pipe_q[DEPTH-1];
    // Includes the output stage, so DONE waits for the last write to retire
    assign busy_o = |vld_pipe_q;

endmodule

// File: rtl/spu_ln_ctrl.sv
// LayerNorm sequencer: statistics pass, divide, sqrt wait, output pass.
// Define SPU_LN_CTRL_TIMEOUT_EN to abort the sqrt wait at sqrt_cnt=255.
module spu_ln_ctrl
    import spu_ln_pkg::*;
#(
    parameter int WADDR_W   = LN_WADDR_W,
    parameter int MAX_WORDS = LN_MAX_WORDS
) (
    input  logic               core_clk,
    input  logic               rst,
    input  logic               start,
    input  logic [9:0]         len_words,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rd_en,
    output logic [WADDR_W-1:0] rd_addr,
    output logic [2:0]         ln_state,
    output logic               sum_en,
    output logic               sum_div_cnt,
    output logic [7:0]         sqrt_cnt,
    input  logic               sum_div_finish,
    input  logic               sqrt_reci_finish,
    output logic               wr_en,
    output logic [WADDR_W-1:0] wr_addr
);

    ln_ctrl_st_e        state_q, state_d;
    logic [9:0]         k_q, k_d;
    logic [9:0]         n_q, n_d;
    logic [7:0]         sqc_q, sqc_d;
    logic               err_q, err_d;
    logic [WADDR_W-1:0] rd_addr_q;
    logic               pipe_busy;

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            sqc_q     <= '0;
            err_q     <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            sqc_q   <= sqc_d;
            err_q   <= err_d;
            if (rd_en) rd_addr_q <= rd_addr;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        err_d       = err_q;
        rd_en       = 1'b0;
        sum_en      = 1'b0;
        sum_div_cnt = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    n_d     = ln_clamp_len(len_words, MAX_WORDS);
                    k_d     = '0;
                    state_d = (n_d == '0) ? ST_DONE : ST_SUM_COUNT;
                end
            end
            ST_SUM_COUNT: begin
                rd_en  = (k_q < n_q);
                // data lands two cycles after the read: buffer latency + datapath input reg
                sum_en = (k_q >= 10'd2);
                if (k_q == n_q + 10'd1) begin
                    state_d = ST_SUM_DIV;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 10'd1;
                end
            end
            ST_SUM_DIV: begin
                sum_div_cnt = k_q[0];
                if (!k_q[0]) begin
                    k_d = 10'd1;
                end else if (sum_div_finish) begin
                    state_d = ST_SQRT;
                    k_d     = '0;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    k_d     = '0;
                end
            end
            ST_SQRT: begin
                if (sqrt_reci_finish) begin
                    state_d = ST_OUT;
                    k_d     = '0;
                end
`ifdef SPU_LN_CTRL_TIMEOUT_EN
                else if (sqc_q == 8'hFF) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_OUT: begin
                rd_en = (k_q < n_q);
                if (k_q == n_q + 10'd1) begin
                    state_d = ST_DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 10'd1;
                end
            end
            ST_DONE: begin
                if (!pipe_busy) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter restarts from 0 on every SQRT entry and is 0 elsewhere
        sqc_d = '0;
        if (state_q == ST_SQRT && state_d == ST_SQRT)
            sqc_d = (sqc_q == 8'hFF) ? sqc_q : sqc_q + 8'd1;
    end

    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;
    assign rd_addr  = rd_en ? WADDR_W'(k_q) : rd_addr_q;
    assign ln_state = (state_q == ST_DONE) ? LN_IDLE : state_q;
    assign sqrt_cnt = sqc_q;

    spu_ln_wr_delay #(
        .AW    (WADDR_W),
        .DEPTH (LN_WR_LAT)
    ) u_wr_dly (
        .clk_i  (core_clk),
        .rst_i  (rst),
        .vld_i  (rd_en && state_q == ST_OUT),
        .addr_i (rd_addr),
        .vld_o  (wr_en),
        .addr_o (wr_addr),
        .busy_o (pipe_busy)
    );

endmodule

// File: tb/tb_spu_ln_ctrl.sv
// Directed bench for spu_ln_ctrl with a minimal datapath responder.
// Honours SPU_LN_CTRL_TIMEOUT_EN for the missing-sqrt-finish scenario.
module tb_spu_ln_ctrl;

    logic       core_clk = 1'b0;
    logic       rst, start, sum_div_finish, sqrt_reci_finish;
    logic [9:0] len_words;
    logic       busy, done, err, rd_en, sum_en, sum_div_cnt, wr_en;
    logic [8:0] rd_addr, wr_addr;
    logic [2:0] ln_state;
    logic [7:0] sqrt_cnt;

    int n_vec = 0, n_bad = 0, cyc = 0;
    int fin_at = 0;
    bit sf_en = 0, df_en = 0, stray_en = 0;
    int rd_cyc[$], rd_adr[$], rd_ph[$], sum_cyc[$], wr_cyc[$], wr_adr[$], sdiv[$];

    spu_ln_ctrl dut (
        .core_clk(core_clk), .rst(rst), .start(start), .len_words(len_words),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
        .ln_state(ln_state), .sum_en(sum_en), .sum_div_cnt(sum_div_cnt),
        .sqrt_cnt(sqrt_cnt), .sum_div_finish(sum_div_finish),
        .sqrt_reci_finish(sqrt_reci_finish), .wr_en(wr_en), .wr_addr(wr_addr)
    );

    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) cyc++;

    // Datapath responder plus event recorder, both on the falling edge
    always @(negedge core_clk) begin
        sum_div_finish   = df_en && ln_state == 3'b011 && sum_div_cnt;
        sqrt_reci_finish = (sf_en && ln_state == 3'b100 && sqrt_cnt == 8'(fin_at)) ||
                           (stray_en && ln_state == 3'b001);
        if (rd_en) begin
            rd_cyc.push_back(cyc); rd_adr.push_back(int'(rd_addr)); rd_ph.push_back(int'(ln_state));
        end
        if (sum_en) sum_cyc.push_back(cyc);
        if (wr_en) begin wr_cyc.push_back(cyc); wr_adr.push_back(int'(wr_addr)); end
        if (ln_state == 3'b011) sdiv.push_back(cyc * 2 + int'(sum_div_cnt));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        rd_cyc.delete(); rd_adr.delete(); rd_ph.delete(); sum_cyc.delete();
        wr_cyc.delete(); wr_adr.delete(); sdiv.delete();
    endtask

    // Pulses start and waits (bounded) for done; returns at the done cycle's falling edge
    task automatic run(input int len, input int fin, input bit dfe, input int poke,
                       output int t0, output int dc);
        bit got = 0;
        clr();
        fin_at = fin; sf_en = (fin >= 0); df_en = dfe;
        @(negedge core_clk);
        len_words = 10'(len); start = 1'b1; t0 = cyc; dc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge core_clk);
            start = (poke > 0 && cyc == t0 + poke);
            if (start) len_words = 10'd2;
            if (done) begin got = 1; dc = cyc; break; end
        end
        start = 1'b0;
        n_vec++;
        if (!got) begin n_bad++; $display("FAIL run_timeout len=%0d: done not seen in 3000 cycles", len); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len_words = '0;
        repeat (3) @(negedge core_clk);
        for (int p = 0; p < 2; p++) begin
            n_vec++;
            if ({busy, done, err, rd_en, sum_en, sum_div_cnt, wr_en} !== 7'd0) begin
                n_bad++; $display("FAIL reset_strobes p%0d: got %b want 0", p,
                                  {busy, done, err, rd_en, sum_en, sum_div_cnt, wr_en});
            end
            n_vec++;
            if ({ln_state, sqrt_cnt, rd_addr, wr_addr} !== 29'd0) begin
                n_bad++; $display("FAIL reset_values p%0d: state=%0d sqrt=%0d ra=%0d wa=%0d want 0",
                                  p, ln_state, sqrt_cnt, rd_addr, wr_addr);
            end
            rst = 1'b0;
            @(negedge core_clk);
        end
    endtask

    task automatic test_single();
        int t0, dc, o0;
        run(1, 5, 1, 0, t0, dc);
        o0 = t0 + 12;
        n_vec++;
        if (rd_cyc.size() != 2 || rd_cyc[0] != t0 + 1 || rd_cyc[1] != o0 || rd_adr[0] != 0 || rd_adr[1] != 0) begin
            n_bad++; $display("FAIL n1_reads: n=%0d want 2 at t+1 and t+12 addr 0", rd_cyc.size());
        end
        n_vec++;
        if (sum_cyc.size() != 1 || sum_cyc[0] != t0 + 3) begin
            n_bad++; $display("FAIL n1_sum_en: n=%0d want 1 at t+3", sum_cyc.size());
        end
        n_vec++;
        if (sdiv.size() != 2 || sdiv[0] != (t0 + 4) * 2 || sdiv[1] != (t0 + 5) * 2 + 1) begin
            n_bad++; $display("FAIL n1_sum_div: n=%0d want cnt 0 at t+4, 1 at t+5", sdiv.size());
        end
        n_vec++;
        if (wr_cyc.size() != 1 || wr_cyc[0] != o0 + 3 || wr_adr[0] != 0) begin
            n_bad++; $display("FAIL n1_write: n=%0d want 1 at t+15 addr 0", wr_cyc.size());
        end
        n_vec++;
        if (dc - t0 != 16 || err !== 1'b0) begin
            n_bad++; $display("FAIL n1_done: latency=%0d err=%b want 16 err 0", dc - t0, err);
        end
        @(negedge core_clk);
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL n1_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_four();
        int t0, dc, o0;
        stray_en = 1;
        run(4, 2, 1, 0, t0, dc);
        stray_en = 0;
        o0 = t0 + 12;
        n_vec++;
        if (rd_cyc.size() != 8) begin
            n_bad++; $display("FAIL n4_read_count: got %0d want 8", rd_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (rd_adr[i] != i % 4 || rd_cyc[i] != (i < 4 ? t0 + 1 + i : o0 + i - 4) ||
                    rd_ph[i] != (i < 4 ? 1 : 6)) begin
                    n_bad++; $display("FAIL n4_read%0d: addr=%0d cyc=t+%0d ph=%0d", i, rd_adr[i], rd_cyc[i] - t0, rd_ph[i]);
                end
            end
        end
        n_vec++;
        if (sum_cyc.size() != 4 || sum_cyc[0] != t0 + 3 || sum_cyc[3] != t0 + 6) begin
            n_bad++; $display("FAIL n4_sum_en: n=%0d want 4 at t+3..t+6", sum_cyc.size());
        end
        n_vec++;
        if (wr_cyc.size() != 4) begin
            n_bad++; $display("FAIL n4_write_count: got %0d want 4", wr_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (wr_adr[i] != i || wr_cyc[i] != o0 + 3 + i) begin
                    n_bad++; $display("FAIL n4_write%0d: addr=%0d cyc=t+%0d want %0d t+%0d", i, wr_adr[i], wr_cyc[i] - t0, i, 15 + i);
                end
            end
        end
        n_vec++;
        if (dc - t0 != 19) begin n_bad++; $display("FAIL n4_latency: got %0d want 19", dc - t0); end
        @(negedge core_clk);
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL n4_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_zero();
        int t0, dc;
        run(0, 0, 1, 0, t0, dc);
        n_vec++;
        if (dc - t0 != 1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL len0_done: latency=%0d busy=%b want 1 1", dc - t0, busy);
        end
        @(negedge core_clk);
        n_vec++;
        if (rd_cyc.size() != 0 || wr_cyc.size() != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL len0_quiet: rd=%0d wr=%0d busy=%b want 0 0 0", rd_cyc.size(), wr_cyc.size(), busy);
        end
    endtask

    task automatic test_clamp();
        int t0, dc;
        run(700, 0, 1, 0, t0, dc);
        n_vec++;
        if (rd_cyc.size() != 1024 || rd_adr[511] != 511 || rd_adr[1023] != 511) begin
            n_bad++; $display("FAIL clamp_reads: n=%0d want 1024 last addr 511", rd_cyc.size());
        end
        n_vec++;
        if (wr_cyc.size() != 512 || wr_adr[511] != 511) begin
            n_bad++; $display("FAIL clamp_writes: n=%0d want 512 last addr 511", wr_cyc.size());
        end
        n_vec++;
        if (dc - t0 != 1033) begin n_bad++; $display("FAIL clamp_latency: got %0d want 1033", dc - t0); end
        @(negedge core_clk);
    endtask

    task automatic test_start_ignored();
        int t0, dc;
        run(4, 2, 1, 8, t0, dc);
        n_vec++;
        if (rd_cyc.size() != 8 || wr_cyc.size() != 4 || dc - t0 != 19) begin
            n_bad++; $display("FAIL midrun_start: rd=%0d wr=%0d lat=%0d want 8 4 19", rd_cyc.size(), wr_cyc.size(), dc - t0);
        end
        start = 1'b1; len_words = 10'd4;
        @(negedge core_clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || ln_state !== 3'b000) begin
            n_bad++; $display("FAIL start_at_done: busy=%b rd_en=%b state=%0d want 0 0 0", busy, rd_en, ln_state);
        end
        @(negedge core_clk);
    endtask

    task automatic test_div_err();
        int t0, dc;
        run(3, -1, 0, 0, t0, dc);
        n_vec++;
        if (err !== 1'b1 || dc - t0 != 8 || rd_cyc.size() != 3 || wr_cyc.size() != 0) begin
            n_bad++; $display("FAIL div_err: err=%b lat=%0d rd=%0d wr=%0d want 1 8 3 0", err, dc - t0, rd_cyc.size(), wr_cyc.size());
        end
        run(1, 0, 1, 0, t0, dc);
        n_vec++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
        @(negedge core_clk);
    endtask

    task automatic test_no_finish();
`ifdef SPU_LN_CTRL_TIMEOUT_EN
        int t0, dc;
        run(2, -1, 1, 0, t0, dc);
        n_vec++;
        if (err !== 1'b1 || dc - t0 != 263 || rd_cyc.size() != 2 || wr_cyc.size() != 0) begin
            n_bad++; $display("FAIL sqrt_timeout: err=%b lat=%0d rd=%0d wr=%0d want 1 263 2 0", err, dc - t0, rd_cyc.size(), wr_cyc.size());
        end
        @(negedge core_clk);
`else
        bit seen_done = 0;
        clr(); sf_en = 0; df_en = 1;
        @(negedge core_clk);
        len_words = 10'd2; start = 1'b1;
        @(negedge core_clk);
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge core_clk);
            if (done) seen_done = 1;
        end
        n_vec++;
        if (ln_state !== 3'b100 || sqrt_cnt !== 8'd255 || busy !== 1'b1) begin
            n_bad++; $display("FAIL sqrt_wait: state=%0d cnt=%0d busy=%b want 4 255 1", ln_state, sqrt_cnt, busy);
        end
        n_vec++;
        if (seen_done || rd_cyc.size() != 2 || err !== 1'b0) begin
            n_bad++; $display("FAIL sqrt_wait_quiet: done=%b rd=%0d err=%b want 0 2 0", seen_done, rd_cyc.size(), err);
        end
        rst = 1'b1;
        @(negedge core_clk);
        rst = 1'b0;
        @(negedge core_clk);
`endif
    endtask

    task automatic test_reset_mid();
        int t0, dc, nw = 0;
        clr(); fin_at = 1; sf_en = 1; df_en = 1;
        @(negedge core_clk);
        len_words = 10'd4; start = 1'b1;
        @(negedge core_clk);
        start = 1'b0;
        for (int i = 0; i < 100 && nw < 2; i++) begin
            @(negedge core_clk);
            if (wr_en) nw++;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (nw != 2 || {busy, rd_en, wr_en, sum_en, done} !== 5'd0 || ln_state !== 3'b000 ||
            rd_addr !== 9'd0 || wr_addr !== 9'd0) begin
            n_bad++; $display("FAIL rst_mid_outputs: nw=%0d busy=%b wr=%b state=%0d ra=%0d wa=%0d want 2 0 0 0 0 0",
                              nw, busy, wr_en, ln_state, rd_addr, wr_addr);
        end
        clr();
        repeat (2) @(negedge core_clk);
        rst = 1'b0;
        repeat (8) @(negedge core_clk);
        n_vec++;
        if (wr_cyc.size() != 0 || rd_cyc.size() != 0) begin
            n_bad++; $display("FAIL rst_mid_quiet: wr=%0d rd=%0d want 0 0", wr_cyc.size(), rd_cyc.size());
        end
        run(2, 1, 1, 0, t0, dc);
        n_vec++;
        if (wr_cyc.size() != 2 || wr_adr[0] != 0 || wr_adr[1] != 1 || wr_cyc[0] != t0 + 12 || dc - t0 != 14) begin
            n_bad++; $display("FAIL rst_mid_rerun: wr=%0d lat=%0d want 2 14", wr_cyc.size(), dc - t0);
        end
        @(negedge core_clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_four();
        test_zero();
        test_clamp();
        test_start_ignored();
        test_div_err();
        test_no_finish();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
